// File: rtl/vga_scan_gen.sv
// -----------------------------------------------------------------------------
// vga_scan_gen
//
// Raster scan generator. It produces the DrawX/DrawY pixel coordinates seen by
// every per-pixel consumer, plus VGA sync and blank. It also owns RoomNum.
// Game logic requests room changes over a valid/ready handshake. A change is
// applied only at the start of vertical blank, so a frame never tears.
//
// Ports
//   Clk            in   system clock
//   Reset          in   synchronous, active-high reset
//   room_req       in   [2:0] requested room number
//   room_req_valid in   request valid
//   room_req_ready out  request can be accepted (no request pending)
//   pixel_ce       out  pixel-advance enable, high one Clk cycle per pixel
//   DrawX          out  [9:0] current pixel column (0..H_TOTAL-1)
//   DrawY          out  [9:0] current pixel row    (0..V_TOTAL-1)
//   VGA_HS         out  horizontal sync, active low
//   VGA_VS         out  vertical sync, active low
//   VGA_BLANK_N    out  high while inside the visible area
//   frame_start    out  one-cycle pulse when the counters enter (0,0)
//   RoomNum        out  [2:0] current room, stable for a whole frame
// -----------------------------------------------------------------------------
module vga_scan_gen #(
    parameter int       H_VISIBLE  = 640,
    parameter int       H_FRONT    = 16,
    parameter int       H_SYNC     = 96,
    parameter int       H_BACK     = 48,
    parameter int       V_VISIBLE  = 480,
    parameter int       V_FRONT    = 10,
    parameter int       V_SYNC     = 2,
    parameter int       V_BACK     = 33,
    parameter int       CLK_DIV    = 2,
    parameter logic [2:0] RESET_ROOM = 3'd7
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [2:0] room_req,
    input  logic       room_req_valid,
    output logic       room_req_ready,
    output logic       pixel_ce,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       frame_start,
    output logic [2:0] RoomNum
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // With CLK_DIV=1 the divider collapses to a single bit that stays 0.
    localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic             r_hs;
    logic             r_vs;
    logic             r_blank_n;
    logic             r_frame_start;
    logic [2:0]       r_room;
    logic             r_pending;
    logic [2:0]       r_pending_room;

    logic             w_pixel_ce;
    logic [9:0]       w_x_nxt;
    logic [9:0]       w_y_nxt;
    logic             w_vblank_edge;
    logic             w_frame_edge;

    assign w_pixel_ce = (r_div_cnt == DIV_LAST);

    // Pixel clock-enable divider.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_div_cnt <= '0;
        end else if (w_pixel_ce) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Next raster position; everything registered below is derived from it
    // so sync/blank line up with the coordinates presented in the same cycle.
    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        if (w_pixel_ce) begin
            if (r_x == H_LAST) begin
                w_x_nxt = '0;
                w_y_nxt = (r_y == V_LAST) ? 10'd0 : r_y + 10'd1;
            end else begin
                w_x_nxt = r_x + 10'd1;
            end
        end
    end

    // Qualified with pixel_ce so a held (0,0) or (0,V_VISIBLE) is not re-seen.
    assign w_frame_edge  = w_pixel_ce && (w_x_nxt == 10'd0) && (w_y_nxt == 10'd0);
    assign w_vblank_edge = w_pixel_ce && (w_x_nxt == 10'd0) && (w_y_nxt == V_VIS);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_x           <= '0;
            r_y           <= '0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank_n     <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_hs          <= !((w_x_nxt >= HS_START) && (w_x_nxt < HS_END));
            r_vs          <= !((w_y_nxt >= VS_START) && (w_y_nxt < VS_END));
            r_blank_n     <= (w_x_nxt < H_VIS) && (w_y_nxt < V_VIS);
            r_frame_start <= w_frame_edge;
        end
    end

    // Room handshake. Apply takes priority; since ready is low while a request
    // is pending, an accept can only coincide with the vblank edge when nothing
    // was pending, and that new request then waits for the following frame.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_room    <= RESET_ROOM;
            r_pending <= 1'b0;
        end else if (w_vblank_edge && r_pending) begin
            r_room    <= r_pending_room;
            r_pending <= 1'b0;
        end else if (room_req_valid && !r_pending) begin
            r_pending <= 1'b1;
        end
    end

    // Payload register only loads on accept; it needs no reset.
    always_ff @(posedge Clk) begin
        if (room_req_valid && !r_pending && !Reset) begin
            r_pending_room <= room_req;
        end
    end

    assign room_req_ready = !r_pending;
    assign pixel_ce       = w_pixel_ce;
    assign DrawX          = r_x;
    assign DrawY          = r_y;
    assign VGA_HS         = r_hs;
    assign VGA_VS         = r_vs;
    assign VGA_BLANK_N    = r_blank_n;
    assign frame_start    = r_frame_start;
    assign RoomNum        = r_room;

endmodule

// File: tb/tb_vga_scan_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_scan_gen
//
// Two instances share one clock: one with CLK_DIV=2 and one with CLK_DIV=1.
// Both use a shrunken raster so that several whole frames fit in a short run.
// The reference model keeps only a count of clock edges since reset. Pixel
// position, sync, blank and frame_start are derived from that count with
// plain arithmetic. Room state follows the handshake/apply rules event by
// event.
// -----------------------------------------------------------------------------
module tb_vga_scan_gen;

    localparam int HV = 20, HF = 4, HSY = 6, HB = 5;
    localparam int VV = 12, VF = 2, VSY = 2, VB = 3;
    localparam int HT = HV + HF + HSY + HB;
    localparam int VT = VV + VF + VSY + VB;
    localparam int FR = HT * VT;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       rst_a, va, rdy_a, ce_a, hs_a, vs_a, bl_a, fs_a;
    logic [2:0] qa, room_a;
    logic [9:0] x_a, y_a;
    logic       rst_b, vb, rdy_b, ce_b, hs_b, vs_b, bl_b, fs_b;
    logic [2:0] qb, room_b;
    logic [9:0] x_b, y_b;

    vga_scan_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .CLK_DIV(2), .RESET_ROOM(3'd7)
    ) u_a (
        .Clk(Clk), .Reset(rst_a), .room_req(qa), .room_req_valid(va),
        .room_req_ready(rdy_a), .pixel_ce(ce_a), .DrawX(x_a), .DrawY(y_a),
        .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_BLANK_N(bl_a),
        .frame_start(fs_a), .RoomNum(room_a)
    );

    vga_scan_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .CLK_DIV(1), .RESET_ROOM(3'd7)
    ) u_b (
        .Clk(Clk), .Reset(rst_b), .room_req(qb), .room_req_valid(vb),
        .room_req_ready(rdy_b), .pixel_ce(ce_b), .DrawX(x_b), .DrawY(y_b),
        .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_BLANK_N(bl_b),
        .frame_start(fs_b), .RoomNum(room_b)
    );

    int         n_total = 0;
    int         n_bad   = 0;
    int         cyc     = 0;
    int         k[2];
    int         pend[2];
    logic [2:0] proom[2];
    logic [2:0] room_m[2];
    int         last_fs[2];
    bit         rand_a = 1'b1;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int dv(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int pix(input int i);
        return (k[i] / dv(i)) % FR;
    endfunction

    function automatic int mx(input int i);
        return pix(i) % HT;
    endfunction

    function automatic int my(input int i);
        return pix(i) / HT;
    endfunction

    // One clock edge of the reference model for instance i.
    task automatic model_edge(input int i, input logic r, input logic v, input logic [2:0] q);
        bit apply;
        if (r) begin
            k[i]      = 0;
            room_m[i] = 3'd7;
            pend[i]   = 0;
            last_fs[i] = -1;
        end else begin
            k[i]++;
            apply = (k[i] % dv(i) == 0) && (pix(i) == VV * HT);
            if (apply && pend[i] != 0) begin
                room_m[i] = proom[i];
                pend[i]   = 0;
            end else if (v && pend[i] == 0) begin
                pend[i]  = 1;
                proom[i] = q;
            end
        end
    endtask

    task automatic check_dut(input int i, input logic [9:0] x, input logic [9:0] y,
                             input logic hs, input logic vs, input logic bl, input logic fs,
                             input logic ce, input logic [2:0] room, input logic rdy);
        int    ex, ey;
        string s;
        ex = mx(i);
        ey = my(i);
        s  = (i == 0) ? "a" : "b";
        chk({s, ".pixel_ce"}, ce, int'(k[i] % dv(i) == dv(i) - 1));
        chk({s, ".DrawX"}, x, ex);
        chk({s, ".DrawY"}, y, ey);
        chk({s, ".VGA_HS"}, hs, int'(!(ex >= HV + HF && ex < HV + HF + HSY)));
        chk({s, ".VGA_VS"}, vs, int'(!(ey >= VV + VF && ey < VV + VF + VSY)));
        chk({s, ".BLANK_N"}, bl, int'(ex < HV && ey < VV));
        chk({s, ".frame_start"}, fs, int'(k[i] > 0 && k[i] % dv(i) == 0 && pix(i) == 0));
        chk({s, ".RoomNum"}, room, room_m[i]);
        chk({s, ".ready"}, rdy, int'(pend[i] == 0));
        if (fs) begin
            if (last_fs[i] >= 0) chk({s, ".frame_period"}, cyc - last_fs[i], dv(i) * FR);
            last_fs[i] = cyc;
        end
    endtask

    task automatic step();
        @(posedge Clk);
        cyc++;
        model_edge(0, rst_a, va, qa);
        model_edge(1, rst_b, vb, qb);
        #1;
        check_dut(0, x_a, y_a, hs_a, vs_a, bl_a, fs_a, ce_a, room_a, rdy_a);
        check_dut(1, x_b, y_b, hs_b, vs_b, bl_b, fs_b, ce_b, room_b, rdy_b);
        vb = ($urandom_range(0, 99) < 4);
        qb = 3'($urandom);
        if (rand_a) begin
            va = ($urandom_range(0, 99) < 4);
            qa = 3'($urandom);
        end
    endtask

    // Advance instance a until the model reaches (wx,wy), optionally with
    // nothing pending; a bounded search that counts as a failure on timeout.
    task automatic wait_a(input int wx, input int wy, input bit need_idle, input string tag);
        bit hit = 1'b0;
        for (int n = 0; n < 4 * 2 * FR && !hit; n++) begin
            step();
            hit = (mx(0) == wx) && (my(0) == wy) && (!need_idle || pend[0] == 0);
        end
        if (!hit) chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        va = 1'b0; vb = 1'b0; qa = 3'd0; qb = 3'd0;
        for (int i = 0; i < 2; i++) begin
            k[i] = 0; pend[i] = 0; proom[i] = 3'd0; room_m[i] = 3'd7; last_fs[i] = -1;
        end
        rand_a = 1'b0;
        repeat (3) step();
        chk("reset.DrawX", x_a, 0);
        chk("reset.RoomNum", room_a, 7);
        chk("reset.ready", rdy_a, 1);
        chk("reset.HS", hs_a, 1);
        chk("reset.frame_start", fs_a, 0);
        chk("reset.b_pixel_ce", ce_b, 1);
        rst_a = 1'b0; rst_b = 1'b0;
        rand_a = 1'b1;

        // Free-running random traffic over several frames.
        repeat (2 * 2 * FR + 400) step();

        // Request mid-frame, applied at vblank start.
        rand_a = 1'b0; va = 1'b0;
        wait_a(0, 3, 1'b1, "t3_arm");
        va = 1'b1; qa = 3'd1;
        step();
        va = 1'b0;
        chk("t3_ready_drop", rdy_a, 0);
        wait_a(0, VV, 1'b1, "t3_apply");
        chk("t3_room_applied", room_a, 1);
        chk("t3_ready_back", rdy_a, 1);

        // Request accepted on the very edge that enters vblank.
        begin
            bit hit = 1'b0;
            for (int n = 0; n < 4 * 2 * FR && !hit; n++) begin
                step();
                hit = ((k[0] + 1) % 2 == 0) && ((((k[0] + 1) / 2) % FR) == VV * HT);
            end
            if (!hit) chk("t4_arm_timeout", 0, 1);
        end
        va = 1'b1; qa = 3'd5;
        step();
        va = 1'b0;
        chk("t4_at_vblank_x", x_a, 0);
        chk("t4_at_vblank_y", y_a, VV);
        chk("t4_room_unchanged", room_a, 1);
        chk("t4_ready_low", rdy_a, 0);
        wait_a(0, VV, 1'b1, "t4_apply");
        chk("t4_room_next_frame", room_a, 5);

        // Reset mid-frame while a request is pending.
        wait_a(0, 2, 1'b1, "t5_arm");
        va = 1'b1; qa = 3'd2;
        step();
        va = 1'b0;
        wait_a(9, 6, 1'b0, "t5_pos");
        chk("t5_pending_before", rdy_a, 0);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        chk("t5_x", x_a, 0);
        chk("t5_y", y_a, 0);
        chk("t5_room", room_a, 7);
        chk("t5_ready", rdy_a, 1);
        chk("t5_hs", hs_a, 1);
        chk("t5_vs", vs_a, 1);
        chk("t5_fs", fs_a, 0);

        // More random traffic after the reset, including a full frame pair.
        rand_a = 1'b1;
        repeat (2 * 2 * FR + 200) step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
